// File: rtl/vir_key_bounce_gen.sv
// Emulates mechanical key bounce: each channel turns a clean level change into a fixed-length
// burst of toggling that settles at the new level.
module vir_key_bounce_gen #(
   parameter int   CH         = 4,
   parameter int   BOUNCE_CYC = 160000,
   parameter int   HALF_PER   = 3,
   parameter logic IDLE_LVL   = 1'b1,
   parameter int   CNT_W      = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CH-1:0] in_sig,
   output logic [CH-1:0] q_sig,
   output logic [CH-1:0] busy
);

   localparam int PH_W = $clog2(HALF_PER) + 1;

   localparam logic StIdle   = 1'b0;
   localparam logic StBounce = 1'b1;

   localparam logic [CNT_W-1:0] WinLast = CNT_W'(BOUNCE_CYC - 1);
   localparam logic [PH_W-1:0]  PhLast  = PH_W'(HALF_PER - 1);

   if (HALF_PER < 1) begin : g_bad_half_per
      $error("vir_key_bounce_gen: HALF_PER must be >= 1");
   end
   if (BOUNCE_CYC < 2) begin : g_bad_bounce_min
      $error("vir_key_bounce_gen: BOUNCE_CYC must be >= 2");
   end
   if (64'(BOUNCE_CYC) > (64'd1 << CNT_W)) begin : g_bad_bounce_max
      $error("vir_key_bounce_gen: BOUNCE_CYC does not fit in CNT_W");
   end

   logic [CH-1:0] s1_q;
   logic [CH-1:0] s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= {CH{IDLE_LVL}};
         s2_q <= {CH{IDLE_LVL}};
      end else begin
         s1_q <= in_sig;
         s2_q <= s1_q;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic             state_q, state_d;
      logic             tgt_q, tgt_d;
      logic             lvl_q, lvl_d;
      logic             busy_q, busy_d;
      logic [CNT_W-1:0] wcnt_q, wcnt_d;
      logic [PH_W-1:0]  phase_q, phase_d;

      always_comb begin
         state_d = state_q;
         tgt_d   = tgt_q;
         lvl_d   = lvl_q;
         busy_d  = busy_q;
         wcnt_d  = '0;
         phase_d = '0;
         unique case (state_q)
            StIdle: begin
               busy_d = 1'b0;
               if (en && (s2_q[i] != lvl_q)) begin
                  state_d = StBounce;
                  tgt_d   = s2_q[i];
                  lvl_d   = s2_q[i];
                  busy_d  = 1'b1;
               end
            end
            StBounce: begin
               // Window end wins over a toggle landing on the same edge.
               if (wcnt_q == WinLast) begin
                  state_d = StIdle;
                  lvl_d   = tgt_q;
                  busy_d  = 1'b0;
               end else begin
                  wcnt_d = wcnt_q + CNT_W'(1);
                  if (phase_q == PhLast) begin
                     lvl_d = ~lvl_q;
                  end else begin
                     phase_d = phase_q + PH_W'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= StIdle;
            tgt_q   <= IDLE_LVL;
            lvl_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            wcnt_q  <= '0;
            phase_q <= '0;
         end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            lvl_q   <= lvl_d;
            busy_q  <= busy_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
         end
      end

      assign q_sig[i] = lvl_q;
      assign busy[i]  = busy_q;
   end

endmodule

// File: tb/tb_vir_key_bounce_gen.sv
// Directed bench for vir_key_bounce_gen with CH=2, BOUNCE_CYC=20, HALF_PER=3, IDLE_LVL=1.
module tb_vir_key_bounce_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] in_sig;
   logic [1:0] q_sig;
   logic [1:0] busy;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   vir_key_bounce_gen #(
      .CH        (2),
      .BOUNCE_CYC(20),
      .HALF_PER  (3),
      .IDLE_LVL  (1'b1),
      .CNT_W     (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in_sig(in_sig),
      .q_sig (q_sig),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected q after edge k+off when the input changed old->new at sampling edge k.
   function automatic logic exp_q(input int off, input logic old_l, input logic new_l);
      if (off < 2) return old_l;
      if (off >= 22) return new_l;
      return new_l ^ logic'(((off - 2) / 3) % 2);
   endfunction

   function automatic logic exp_b(input int off);
      return (off >= 2) && (off <= 21);
   endfunction

   initial begin
      rst_n  = 1'b0;
      en     = 1'b1;
      in_sig = 2'b11;
      tick(3);
      chk("reset_q", q_sig, 2'b11);
      chk("reset_busy", busy, 2'b00);
      rst_n = 1'b1;
      tick(5);
      chk("post_reset_q", q_sig, 2'b11);
      chk("post_reset_busy", busy, 2'b00);

      // Channel 0 falls; channel 1 must stay quiet.
      in_sig = 2'b10;
      for (int off = 0; off <= 24; off++) begin
         tick(1);
         chk($sformatf("ch0_fall_q_%0d", off), q_sig, {1'b1, exp_q(off, 1'b1, 1'b0)});
         chk($sformatf("ch0_fall_busy_%0d", off), busy, {1'b0, exp_b(off)});
      end

      in_sig = 2'b11;
      tick(30);
      chk("restore0_q", q_sig, 2'b11);

      // Input returns high mid-window: window runs to 0, then a new one toward 1.
      in_sig = 2'b10;
      for (int off = 0; off <= 22; off++) begin
         tick(1);
         chk($sformatf("mid_q_%0d", off), q_sig, {1'b1, exp_q(off, 1'b1, 1'b0)});
         chk($sformatf("mid_busy_%0d", off), busy, {1'b0, exp_b(off)});
         if (off == 9) in_sig = 2'b11;
      end
      for (int off = 2; off <= 24; off++) begin
         tick(1);
         chk($sformatf("rewin_q_%0d", off), q_sig, {1'b1, exp_q(off, 1'b0, 1'b1)});
         chk($sformatf("rewin_busy_%0d", off), busy, {1'b0, exp_b(off)});
      end

      // Both channels start together.
      in_sig = 2'b00;
      for (int off = 0; off <= 24; off++) begin
         tick(1);
         chk($sformatf("both_q_%0d", off), q_sig,
             {exp_q(off, 1'b1, 1'b0), exp_q(off, 1'b1, 1'b0)});
         chk($sformatf("both_busy_%0d", off), busy, {exp_b(off), exp_b(off)});
      end

      in_sig = 2'b11;
      tick(30);
      chk("restore1_q", q_sig, 2'b11);

      // en low blocks the start; raising it starts the window on the next edge.
      en     = 1'b0;
      in_sig = 2'b01;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk($sformatf("en_off_q_%0d", i), q_sig, 2'b11);
         chk($sformatf("en_off_busy_%0d", i), busy, 2'b00);
      end
      en = 1'b1;
      tick(1);
      chk("en_on_q", q_sig, 2'b01);
      chk("en_on_busy", busy, 2'b10);
      en = 1'b0;
      tick(10);
      chk("en_mid_busy", busy, 2'b10);
      en = 1'b1;
      tick(15);
      chk("en_done_q", q_sig, 2'b01);
      chk("en_done_busy", busy, 2'b00);

      // Reset mid-window, then a fresh window on both channels.
      in_sig = 2'b00;
      tick(10);
      chk("prereset_busy", busy, 2'b01);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_q", q_sig, 2'b11);
      chk("async_reset_busy", busy, 2'b00);
      tick(2);
      chk("held_reset_q", q_sig, 2'b11);
      rst_n = 1'b1;
      for (int off = 0; off <= 24; off++) begin
         tick(1);
         chk($sformatf("fresh_q_%0d", off), q_sig,
             {exp_q(off, 1'b1, 1'b0), exp_q(off, 1'b1, 1'b0)});
         chk($sformatf("fresh_busy_%0d", off), busy, {exp_b(off), exp_b(off)});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vir_key_bounce_gen.md
VIR_KEY_BOUNCE_GEN -- requirements
Module: vir_key_bounce_gen

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent key channels.
REQ-002 SHALL have parameter BOUNCE_CYC, default 160000: bounce window length in clk cycles (8 ms at 20 MHz).
REQ-003 SHALL have parameter HALF_PER, default 3: cycles per bounce half-period.
REQ-004 SHALL have parameter IDLE_LVL, default 1'b1: released-key level, used as the reset value of all level state.
REQ-005 SHALL have parameter CNT_W, default 18: width of the per-channel window counter; CNT_W >= clog2(BOUNCE_CYC).
REQ-006 SHALL have port clk  input  1: single clock; all state is on its rising edge.
REQ-007 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port en  input  1: high allows new bounce windows to start.
REQ-009 SHALL have port in_sig  input  CH: clean asynchronous key levels, one bit per channel.
REQ-010 SHALL have port q_sig  output  CH: emulated bouncing key levels.
REQ-011 SHALL have port busy  output  CH: high while a channel's bounce window is active.

Function
REQ-012 SHALL pass each in_sig bit through a two-flop synchronizer (s1 -> s2), both flops reset to IDLE_LVL.
REQ-013 SHALL give each channel its own two-state FSM: IDLE and BOUNCE. Per-channel state: target bit, window counter (CNT_W), phase counter (clog2(HALF_PER)+1 bits).
REQ-014 In IDLE with en=1 and s2 != q_sig, the channel SHALL go to BOUNCE on the next edge. On that same edge: target <= s2, q_sig <= s2, busy <= 1, window counter <= 0, phase <= 0.
REQ-015 In IDLE with en=0, or with s2 == q_sig, the channel SHALL hold q_sig, keep busy=0 and keep its counters at 0.
REQ-016 In BOUNCE, the window counter SHALL increment on every cycle.
REQ-017 In BOUNCE, phase SHALL increment on every cycle. When phase == HALF_PER-1, phase SHALL clear to 0 and q_sig SHALL invert.
REQ-018 In BOUNCE, when window counter == BOUNCE_CYC-1, the channel SHALL on that edge set q_sig <= target, busy <= 0, go to IDLE and clear both counters.
REQ-019 The terminal event of REQ-018 SHALL take priority over a coincident toggle.
REQ-020 A bounce window SHALL last exactly BOUNCE_CYC cycles. q_sig SHALL hold target for HALF_PER cycles, then alternate every HALF_PER cycles, then settle at target.
REQ-021 Changes of in_sig during BOUNCE SHALL NOT alter target or timing.
REQ-022 If s2 != q_sig once the channel is back in IDLE, a new window SHALL start on the next edge (given en=1).
REQ-023 Latency: an in_sig change sampled at edge k SHALL produce q_sig = new level and busy=1 after edge k+2.
REQ-024 Deasserting en mid-window SHALL NOT abort the window; en only gates window starts.
REQ-025 Channels SHALL be fully independent; simultaneous starts and terminations on several channels SHALL be allowed.
REQ-026 q_sig and busy SHALL be driven directly from registers, with no combinational path from inputs.
REQ-027 Elaboration SHALL fail if HALF_PER < 1, BOUNCE_CYC < 2, or BOUNCE_CYC > 2**CNT_W.

Reset
REQ-028 While rst_n=0, every channel SHALL immediately hold: q_sig = IDLE_LVL, busy = 0, state IDLE, counters 0, synchronizers = IDLE_LVL. This includes reset asserted mid-window.
REQ-029 After rst_n rises, a channel whose in_sig equals IDLE_LVL SHALL stay IDLE with no output activity.

Verification (CH=2, BOUNCE_CYC=20, HALF_PER=3, IDLE_LVL=1)
REQ-030 Reset with in_sig=2'b11 -> q_sig=2'b11 and busy=2'b00 during and after reset.
REQ-031 in_sig[0] 1->0 sampled at edge k, en=1 -> q_sig[0] follows this sequence, then stays 0:
- 0 from edge k+2
- toggles at edges k+5, k+8, ... k+20
- settles to 0 at edge k+22, with busy[0]=1 over edges k+2..k+21
q_sig[1] stays 1 throughout.
REQ-032 in_sig[0] returns to 1 at edge k+10 during the window above -> the window still ends at 0 at edge k+22, then a new window toward 1 starts at edge k+23.
REQ-033 Both channels change at the same edge -> identical, independent waveforms on q_sig[1:0] and busy[1:0].
REQ-034 en=0 while in_sig[1] goes 1->0 -> q_sig[1]=1, busy[1]=0. Raising en at edge m -> window starts at edge m+1.
REQ-035 rst_n pulsed low mid-window -> q_sig=2'b11 and busy=0 asynchronously. After release with in_sig low, a fresh full window of 20 cycles.
